// File: rtl/mux4to1_pkt_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : mux4_arb_pkg                                               |
// | Brief   : Shared constants and types for the 4:1 packet arbiter      |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package mux4_arb_pkg;

  localparam int N_CH  = 4;
  localparam int SEL_W = 2;

  // Pointer value after reset: the search starts at ptr+1, so channel 0
  // is the first one considered.
  localparam logic [SEL_W-1:0] RR_RESET_PTR = 2'd3;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // Decode a channel index into a one-hot lane mask.
  function automatic logic [N_CH-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
    logic [N_CH-1:0] mask;
    mask      = '0;
    mask[sel] = 1'b1;
    return mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mux4to1_pkt_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface : mux4to1_pkt_arbiter_if                                   |
// | Brief     : Four input lanes plus the merged output stream           |
// | Rev       : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
interface mux4to1_pkt_arbiter_if #(
  parameter int DATA_W = 8
);
  import mux4_arb_pkg::*;

  logic [N_CH-1:0]        in_valid;
  logic [N_CH-1:0]        in_last;
  logic [N_CH*DATA_W-1:0] in_data;
  logic [N_CH-1:0]        in_ready;
  logic                   out_valid;
  logic                   out_last;
  logic [DATA_W-1:0]      out_data;
  logic [SEL_W-1:0]       out_sel;
  logic                   out_ready;

  // Arbiter side
  modport slave (
    input  in_valid, in_last, in_data, out_ready,
    output in_ready, out_valid, out_last, out_data, out_sel
  );

  // Environment side: lane sources and the downstream sink
  modport master (
    output in_valid, in_last, in_data, out_ready,
    input  in_ready, out_valid, out_last, out_data, out_sel
  );

endinterface
`default_nettype wire

// File: rtl/mux4to1_pkt_arbiter_rr_pick4.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : rr_pick4                                                    |
// | Brief  : Combinational round-robin picker over four requests         |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module rr_pick4
  import mux4_arb_pkg::*;
(
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] last,
  output logic [SEL_W-1:0] gnt,
  output logic             any
);

  logic [SEL_W-1:0] idx;

  // Scan from the farthest candidate (last+4 == last) to the nearest (last+1)
  // so the closest requester after the previous winner overrides the rest.
  always_comb begin
    gnt = last;
    any = 1'b0;
    idx = '0;
    for (int k = N_CH; k >= 1; k--) begin
      idx = last + SEL_W'(k);
      if (req[idx]) begin
        gnt = idx;
        any = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mux4to1_pkt_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : mux4to1_pkt_arbiter                                         |
// | Brief  : Merges four valid/ready packet lanes onto one output using  |
// |          per-packet round-robin arbitration and a registered output  |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module mux4to1_pkt_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter bit LOCK_PKT = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  mux4to1_pkt_arbiter_if.slave bus
);

  arb_state_t        state;
  logic [SEL_W-1:0]  grant;
  logic [SEL_W-1:0]  last_grant;
  logic [SEL_W-1:0]  pick_gnt;
  logic              pick_any;

  logic              out_valid_q;
  logic              out_last_q;
  logic [DATA_W-1:0] out_data_q;
  logic [SEL_W-1:0]  out_sel_q;

  logic              locked;
  logic              out_free;
  logic              accept;
  logic              end_pkt;
  logic [DATA_W-1:0] grant_data;

  rr_pick4 u_pick (
    .req  (bus.in_valid),
    .last (last_grant),
    .gnt  (pick_gnt),
    .any  (pick_any)
  );

  // The output slice can take a beat when it is empty or being drained.
  assign locked     = (state == LOCKED);
  assign out_free   = bus.out_ready || !out_valid_q;
  assign accept     = locked && bus.in_valid[grant] && out_free;
  assign end_pkt    = accept && (bus.in_last[grant] || !LOCK_PKT);
  assign grant_data = bus.in_data[grant*DATA_W +: DATA_W];

  assign bus.in_ready  = (locked && out_free) ? sel_onehot(grant) : '0;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;

  // Arbitration FSM, grant bookkeeping and the output register slice.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      grant       <= '0;
      last_grant  <= RR_RESET_PTR;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            grant <= pick_gnt;
            state <= LOCKED;
          end
        end
        LOCKED: begin
          // Rotation advances only once the packet (or beat) is complete.
          if (end_pkt) begin
            last_grant <= grant;
            state      <= IDLE;
          end
        end
      endcase

      if (accept) begin
        out_valid_q <= 1'b1;
        out_last_q  <= bus.in_last[grant];
        out_data_q  <= grant_data;
        out_sel_q   <= grant;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mux4to1_pkt_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_mux4to1_pkt_arbiter                                      |
// | Brief  : Self-checking bench with a packet-level reference model     |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_mux4to1_pkt_arbiter;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } beat_t;

  typedef struct packed {
    logic [1:0] sel;
    logic [7:0] data;
    logic       last;
  } obeat_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mux4to1_pkt_arbiter_if #(.DATA_W(8)) bus  ();
  mux4to1_pkt_arbiter_if #(.DATA_W(8)) bus2 ();

  mux4to1_pkt_arbiter #(.DATA_W(8), .LOCK_PKT(1'b1)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  mux4to1_pkt_arbiter #(.DATA_W(8), .LOCK_PKT(1'b0)) u_dut_beat (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  // Lane sources: each lane owns a list of beats, consumed in order.
  beat_t  lane_b     [4][32];
  int     lane_n     [4];
  int     lane_pos   [4];
  int     lane_gap   [4];
  int     lane_start [4];

  obeat_t exp_q   [$];
  obeat_t exp_hist[$];
  int     fire_cyc[$];
  int     fire_sel[$];

  int     cyc;
  int     gap_mode;    // 0 none, 1 random 0..3, 2 fixed 3 cycles after beat 2
  int     ready_mode;  // 0 always, 1 random, 2 low inside [low_from, low_to)
  int     low_from, low_to;
  logic   prev_hold;
  obeat_t prev_out;

  int total;
  int bad;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Round-robin rule: first requester after the previous winner.
  function automatic int rr_next(input int last, input logic [3:0] mask);
    for (int k = 1; k <= 4; k++)
      if (mask[(last + k) % 4]) return (last + k) % 4;
    return -1;
  endfunction

  function automatic void add_packet(input int lane, input int len, input int base);
    for (int k = 0; k < len; k++) begin
      lane_b[lane][lane_n[lane]].data = (base < 0) ? 8'($urandom) : 8'(base + k);
      lane_b[lane][lane_n[lane]].last = (k == len - 1);
      lane_n[lane]++;
    end
  endfunction

  function automatic void push_lane_expected(input int lane);
    obeat_t e;
    for (int k = 0; k < lane_n[lane]; k++) begin
      e.sel  = 2'(lane);
      e.data = lane_b[lane][k].data;
      e.last = lane_b[lane][k].last;
      exp_q.push_back(e);
      exp_hist.push_back(e);
    end
  endfunction

  // Packet-level model: all lanes queued from the start, whole packets
  // granted in round-robin order over lanes that still have packets.
  function automatic void build_expected();
    int     pos[4];
    int     last;
    int     pick;
    logic [3:0] mask;
    obeat_t e;
    bit     done;
    last = 3;
    for (int i = 0; i < 4; i++) pos[i] = 0;
    for (int guard = 0; guard < 200; guard++) begin
      for (int i = 0; i < 4; i++) mask[i] = (pos[i] < lane_n[i]);
      if (mask == 4'b0) break;
      pick = rr_next(last, mask);
      done = 1'b0;
      while (!done && pos[pick] < lane_n[pick]) begin
        e.sel  = 2'(pick);
        e.data = lane_b[pick][pos[pick]].data;
        e.last = lane_b[pick][pos[pick]].last;
        exp_q.push_back(e);
        exp_hist.push_back(e);
        done = e.last;
        pos[pick]++;
      end
      last = pick;
    end
  endfunction

  task automatic clear_env();
    for (int i = 0; i < 4; i++) begin
      lane_n[i] = 0; lane_pos[i] = 0; lane_gap[i] = 0; lane_start[i] = 0;
    end
    exp_q.delete(); exp_hist.delete(); fire_cyc.delete(); fire_sel.delete();
    prev_hold = 1'b0; cyc = 0; gap_mode = 0; ready_mode = 0;
    bus.in_valid = '0; bus.in_last = '0; bus.in_data = '0; bus.out_ready = 1'b1;
    bus2.in_valid = '0; bus2.in_last = '0; bus2.in_data = '0; bus2.out_ready = 1'b1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_env();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock of lane/sink activity on the main DUT, with scoreboard checks.
  task automatic cycle();
    logic [3:0]  v, l, acc;
    logic [31:0] d;
    obeat_t      got, e;
    bit          was_last;
    @(negedge clk);
    v = '0; l = '0; d = '0;
    for (int i = 0; i < 4; i++) begin
      if (lane_pos[i] < lane_n[i] && cyc >= lane_start[i] && lane_gap[i] == 0) begin
        v[i]         = 1'b1;
        d[i*8 +: 8]  = lane_b[i][lane_pos[i]].data;
        l[i]         = lane_b[i][lane_pos[i]].last;
      end
    end
    bus.in_valid = v; bus.in_last = l; bus.in_data = d;
    case (ready_mode)
      1:       bus.out_ready = ($urandom_range(0, 3) != 0);
      2:       bus.out_ready = !(cyc >= low_from && cyc < low_to);
      default: bus.out_ready = 1'b1;
    endcase
    #1;
    got = {bus.out_sel, bus.out_data, bus.out_last};
    check_eq("ready_onehot", 32'($countones(bus.in_ready) <= 1), 1);
    if (prev_hold) begin
      check_eq("hold_valid", bus.out_valid, 1);
      check_eq("hold_beat", got, prev_out);
    end
    if (bus.out_valid && !bus.out_ready)
      check_eq("bp_in_ready", bus.in_ready, 0);
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("extra_beat", got, 0);
      end else begin
        e = exp_q.pop_front();
        check_eq("beat", got, e);
      end
      fire_cyc.push_back(cyc);
      fire_sel.push_back(int'(bus.out_sel));
    end
    prev_hold = bus.out_valid && !bus.out_ready;
    prev_out  = got;
    acc       = bus.in_valid & bus.in_ready;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      if (acc[i]) begin
        was_last = lane_b[i][lane_pos[i]].last;
        lane_pos[i]++;
        if (!was_last) begin
          if (gap_mode == 1) lane_gap[i] = $urandom_range(0, 3);
          else if (gap_mode == 2 && lane_pos[i] == 2) lane_gap[i] = 3;
        end
      end else if (lane_gap[i] > 0) begin
        lane_gap[i]--;
      end
    end
    cyc++;
  endtask

  task automatic run_until_done(input string tag, input int budget);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      cycle();
      n++;
    end
    check_eq({tag, "_drained"}, exp_q.size(), 0);
    repeat (3) cycle();
  endtask

  // With the sink always ready: first beat 2 cycles after valid, then one
  // beat per cycle inside a packet and one bubble between packets.
  task automatic check_timing(input string tag);
    if (fire_cyc.size() > 0) check_eq({tag, "_latency"}, fire_cyc[0], 2);
    for (int j = 1; j < fire_cyc.size() && j < exp_hist.size(); j++)
      check_eq({tag, "_spacing"}, fire_cyc[j] - fire_cyc[j-1], exp_hist[j-1].last ? 2 : 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   n;
    int   exp_sel, last_m, nfire;
    int   src_cnt[2];
    int   mdl_cnt[2];
    logic [3:0] acc2;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    clear_env();
    repeat (2) @(negedge clk);

    // Reset values
    check_eq("rst_out_valid", bus.out_valid, 0);
    check_eq("rst_out_last",  bus.out_last,  0);
    check_eq("rst_out_data",  bus.out_data,  0);
    check_eq("rst_out_sel",   bus.out_sel,   0);
    check_eq("rst_in_ready",  bus.in_ready,  0);
    rst = 1'b0;

    // T1: reset mid-packet on ch2, then all four lanes request
    apply_reset();
    add_packet(2, 5, 8'h20);
    build_expected();
    n = 0;
    while (fire_cyc.size() < 3 && n < 30) begin
      cycle();
      n++;
    end
    check_eq("t1_pre_fires", fire_cyc.size(), 3);
    #2 rst = 1'b1;
    #1;
    check_eq("t1_rst_out_valid", bus.out_valid, 0);
    check_eq("t1_rst_in_ready",  bus.in_ready,  0);
    apply_reset();
    for (int i = 0; i < 4; i++) add_packet(i, 2, -1);
    build_expected();
    run_until_done("t1", 100);
    if (fire_sel.size() > 0) check_eq("t1_first_ch0", fire_sel[0], 0);

    // T2: rotation 0,1,2,3,0 with exact bubble spacing
    apply_reset();
    add_packet(0, 2, 8'h00); add_packet(1, 2, 8'h10); add_packet(2, 2, 8'h20);
    add_packet(3, 2, 8'h30); add_packet(0, 2, 8'h08);
    build_expected();
    run_until_done("t2", 100);
    check_timing("t2");

    // T3: ch1 packet locks out a later ch3 request
    apply_reset();
    add_packet(1, 4, 8'hA1);
    add_packet(3, 2, 8'hC0);
    lane_start[3] = 3;
    build_expected();
    run_until_done("t3", 100);
    check_timing("t3");

    // T4: downstream stalls for 5 cycles mid-packet
    apply_reset();
    add_packet(1, 6, 8'h50);
    add_packet(3, 2, 8'h70);
    ready_mode = 2; low_from = 4; low_to = 9;
    build_expected();
    run_until_done("t4", 100);

    // T5: granted ch2 pauses 3 cycles; ch0 arriving meanwhile must wait
    apply_reset();
    add_packet(2, 5, 8'h60);
    add_packet(0, 2, 8'h90);
    lane_start[0] = 2;
    gap_mode = 2;
    push_lane_expected(2);
    push_lane_expected(0);
    run_until_done("t5", 100);

    // Randomized traffic: random packet mix, random gaps and back-pressure
    for (int it = 0; it < 4; it++) begin
      apply_reset();
      for (int i = 0; i < 4; i++)
        for (int p = $urandom_range(0, 3); p > 0; p--)
          add_packet(i, $urandom_range(1, 4), -1);
      gap_mode = 1; ready_mode = 1;
      build_expected();
      run_until_done("rand", 800);
    end

    // T6: beat-level arbitration, ch0 and ch1 streaming continuously
    apply_reset();
    src_cnt[0] = 0; src_cnt[1] = 0; mdl_cnt[0] = 0; mdl_cnt[1] = 0;
    last_m = 3; nfire = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      bus2.in_valid  = 4'b0011;
      bus2.in_last   = 4'b0000;
      bus2.in_data   = {16'h0000, 4'h1, 4'(src_cnt[1]), 4'h0, 4'(src_cnt[0])};
      bus2.out_ready = 1'b1;
      #1;
      if (bus2.out_valid && nfire < 6) begin
        exp_sel = rr_next(last_m, 4'b0011);
        last_m  = exp_sel;
        check_eq("t6_sel",  bus2.out_sel, exp_sel);
        check_eq("t6_data", bus2.out_data, {4'(exp_sel), 4'(mdl_cnt[exp_sel])});
        mdl_cnt[exp_sel]++;
        nfire++;
      end
      acc2 = bus2.in_valid & bus2.in_ready;
      @(posedge clk);
      if (acc2[0]) src_cnt[0]++;
      if (acc2[1]) src_cnt[1]++;
    end
    check_eq("t6_beats", nfire, 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
